// File: rtl/elevator_pkg.sv
// elevator_pkg: shared level codes, queue geometry and entry extraction for the elevator request path.
package elevator_pkg;
  localparam int LVL_W = 2;
  localparam int DEPTH = 4;
  localparam int TAIL_W = 3;
  typedef enum logic [LVL_W-1:0] {
    LVL_A = 2'b00,
    LVL_B = 2'b01,
    LVL_C = 2'b10,
    LVL_D = 2'b11
  } lvl_e;
  function automatic logic [LVL_W-1:0] queue_entry(input logic [DEPTH*LVL_W-1:0] q, input int i);
    return q[LVL_W*i +: LVL_W];
  endfunction
endpackage

// File: rtl/add_new_lvl_logic_lvl_match.sv
// lvl_match: one queue-entry compare; invalid entries are gated off so their contents never reach hit.
module lvl_match
  import elevator_pkg::*;
(
  input  logic [LVL_W-1:0] entry,
  input  logic             idx_valid,
  input  logic [LVL_W-1:0] pressed_lvl,
  output logic             hit
);
  always_comb hit = idx_valid ? (entry == pressed_lvl) : 1'b0;
endmodule

// File: rtl/add_new_lvl_logic.sv
// add_new_lvl_logic: decides whether a pressed level must be appended to the pending-level queue.
module add_new_lvl_logic
  import elevator_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pressed_en,
  input  logic [LVL_W-1:0]       pressed_lvl,
  input  logic [DEPTH*LVL_W-1:0] queue,
  input  logic [TAIL_W-1:0]      tail,
  output logic                   add_new_lvl,
  output logic                   add_new_lvl_q
);
  logic [DEPTH-1:0] hit;
  logic             add_new_lvl_d;
  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    lvl_match u_match (
      .entry       (queue_entry(queue, i)),
      .idx_valid   (TAIL_W'(i) < tail),
      .pressed_lvl (pressed_lvl),
      .hit         (hit[i])
    );
  end
  // tail values past DEPTH count as full
  always_comb add_new_lvl_d = pressed_en & ~|hit & (tail < TAIL_W'(DEPTH));
  assign add_new_lvl = add_new_lvl_d;
  always_ff @(posedge clk) add_new_lvl_q <= reset ? 1'b0 : add_new_lvl_d;
endmodule

// File: tb/tb_add_new_lvl_logic.sv
// tb_add_new_lvl_logic: directed vector table plus reset sequence for add_new_lvl_logic.
module tb_add_new_lvl_logic;
  import elevator_pkg::*;
  logic       clk = 1'b0;
  logic       reset;
  logic       pressed_en;
  logic [1:0] pressed_lvl;
  logic [7:0] queue;
  logic [2:0] tail;
  logic       add_new_lvl;
  logic       add_new_lvl_q;
  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    string      name;
    logic       en;
    logic [1:0] lvl;
    logic [7:0] q;
    logic [2:0] t;
    logic       exp;
  } vec_t;

  add_new_lvl_logic dut (
    .clk           (clk),
    .reset         (reset),
    .pressed_en    (pressed_en),
    .pressed_lvl   (pressed_lvl),
    .queue         (queue),
    .tail          (tail),
    .add_new_lvl   (add_new_lvl),
    .add_new_lvl_q (add_new_lvl_q)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pk(input logic [1:0] e0, e1, e2, e3);
    return {e3, e2, e1, e0};
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [1:0] lvl, input logic [7:0] q, input logic [2:0] t);
    pressed_en = en;
    pressed_lvl = lvl;
    queue = q;
    tail = t;
  endtask

  vec_t v[$];

  initial begin
    v.push_back('{"found_at_1",     1'b1, LVL_A, pk(LVL_C, LVL_A, LVL_D, LVL_B), 3'd2, 1'b0});
    v.push_back('{"only_invalid",   1'b1, LVL_D, pk(LVL_C, LVL_A, LVL_D, LVL_D), 3'd1, 1'b1});
    v.push_back('{"no_press_full",  1'b0, LVL_B, pk(LVL_B, LVL_C, LVL_A, LVL_D), 3'd4, 1'b0});
    v.push_back('{"no_press_empty", 1'b0, LVL_B, pk(LVL_B, LVL_C, LVL_A, LVL_D), 3'd0, 1'b0});
    v.push_back('{"press_empty",    1'b1, LVL_B, pk(LVL_B, LVL_C, LVL_A, LVL_D), 3'd0, 1'b1});
    v.push_back('{"full_t4",        1'b1, LVL_B, pk(LVL_A, LVL_C, LVL_D, LVL_A), 3'd4, 1'b0});
    v.push_back('{"full_t6",        1'b1, LVL_B, pk(LVL_A, LVL_C, LVL_D, LVL_A), 3'd6, 1'b0});
    v.push_back('{"t3_b_invalid",   1'b1, LVL_B, pk(LVL_A, LVL_C, LVL_D, LVL_B), 3'd3, 1'b1});
    v.push_back('{"full_t7",        1'b1, LVL_C, pk(LVL_A, LVL_B, LVL_A, LVL_B), 3'd7, 1'b0});
    v.push_back('{"found_at_2",     1'b1, LVL_C, pk(LVL_A, LVL_B, LVL_C, LVL_D), 3'd3, 1'b0});
    v.push_back('{"found_head",     1'b1, LVL_A, pk(LVL_A, LVL_B, LVL_C, LVL_D), 3'd3, 1'b0});
    v.push_back('{"absent_t3",      1'b1, LVL_D, pk(LVL_A, LVL_B, LVL_C, LVL_D), 3'd3, 1'b1});
    v.push_back('{"x_tail_hit",     1'b1, LVL_A, pk(LVL_A, 2'bxx, 2'bxx, 2'bxx), 3'd1, 1'b0});
    v.push_back('{"x_tail_miss",    1'b1, LVL_B, pk(LVL_A, 2'bxx, 2'bxx, 2'bxx), 3'd1, 1'b1});
    v.push_back('{"x_last_miss",    1'b1, LVL_A, pk(LVL_B, LVL_C, LVL_D, 2'bxx), 3'd3, 1'b1});
    v.push_back('{"no_press_t7",    1'b0, LVL_A, pk(LVL_B, LVL_C, LVL_D, LVL_B), 3'd7, 1'b0});

    reset = 1'b1;
    drive(1'b1, LVL_D, pk(LVL_A, LVL_B, LVL_C, LVL_D), 3'd3);
    @(posedge clk) #1;
    chk("reset_q", add_new_lvl_q, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    foreach (v[k]) begin
      @(negedge clk);
      drive(v[k].en, v[k].lvl, v[k].q, v[k].t);
      #1 chk({v[k].name, "_comb"}, add_new_lvl, v[k].exp);
      @(posedge clk) #1;
      chk({v[k].name, "_q"}, add_new_lvl_q, v[k].exp);
    end

    @(negedge clk);
    drive(1'b1, LVL_D, pk(LVL_A, LVL_B, LVL_C, LVL_D), 3'd3);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk) #1;
      chk("hold_reset_q", add_new_lvl_q, 1'b0);
      chk("hold_reset_comb", add_new_lvl, 1'b1);
    end
    @(negedge clk);
    reset = 1'b0;
    #1 chk("release_q_before_edge", add_new_lvl_q, 1'b0);
    @(posedge clk) #1;
    chk("release_q", add_new_lvl_q, 1'b1);

    @(negedge clk);
    pressed_en = 1'b0;
    #1 chk("drop_en_comb", add_new_lvl, 1'b0);
    chk("drop_en_q_held", add_new_lvl_q, 1'b1);
    @(posedge clk) #1;
    chk("drop_en_q", add_new_lvl_q, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/add_new_lvl_logic.md
Name: add_new_lvl_logic

Overview:
Combinational admission check for the elevator request queue, with one registered copy of the result.
- Decides whether a newly pressed floor level must be appended to the pending-level queue.
- A level is added only when a press is present, the level is not already among the valid queue entries, and the queue has a free slot.
- Sits between the call-button decoder and the queue/tail register block; the queue controller uses add_new_lvl as its write enable.

Parameters:
- LVL_W, 2, bits per level code (A=00, B=01, C=10, D=11).
- DEPTH, 4, number of queue entries.
- TAIL_W, 3, width of tail; must be able to represent 0..DEPTH.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- pressed_en  input  1  a button press is presented this cycle.
- pressed_lvl  input  LVL_W  level code of the press.
- queue  input  DEPTH*LVL_W  packed queue; entry i occupies queue[LVL_W*i+LVL_W-1 : LVL_W*i], entry 0 is the head.
- tail  input  TAIL_W  number of valid entries (0..DEPTH); entries with index >= tail are don't-care.
- add_new_lvl  output  1  combinational: append pressed_lvl this cycle.
- add_new_lvl_q  output  1  add_new_lvl registered on clk.

Behaviour:
- Per entry i: hit_i = (i < tail) & (queue entry i == pressed_lvl).
- Contents of entries at index >= tail, including X/unknown bits, must never affect any output.
- in_queue = OR of all hit_i.
- full = (tail >= DEPTH). Tail values above DEPTH (5..7) are treated as full.
- add_new_lvl = pressed_en & ~in_queue & ~full. Purely combinational, zero-cycle latency; must settle within the same cycle as input changes with no clock edge required.
- pressed_en = 0 forces add_new_lvl = 0 regardless of other inputs.
- tail = 0: queue is empty, so any enabled press yields add_new_lvl = 1.
- add_new_lvl_q: on each rising clk edge, loads add_new_lvl; loads 0 when reset = 1. Reset value 0.
- Reset does not affect the combinational add_new_lvl; it depends only on the current inputs.
- No internal state beyond add_new_lvl_q; no handshake. The consumer samples add_new_lvl at the same edge it writes the queue and increments tail.

Decomposition:
- Shared package elevator_pkg holds:
  - level enum/constants LVL_A=2'b00, LVL_B=2'b01, LVL_C=2'b10, LVL_D=2'b11;
  - LVL_W, DEPTH, TAIL_W;
  - a helper function for extracting queue entry i.
- One natural sub-module: lvl_match (one entry compare: entry, index-valid, pressed_lvl -> hit), instantiated DEPTH times via generate.

Test Plan:
1. pressed_en=1, pressed_lvl=A, entries {C,A,D,B}, tail=2 -> A found at entry 1 -> add_new_lvl=0.
2. pressed_en=1, pressed_lvl=D, entries {C,A,D,D}, tail=1 -> D present only in invalid slots -> add_new_lvl=1; add_new_lvl_q=1 after the next clk edge.
3. pressed_en=0, pressed_lvl=B, entries {B,C,A,D}, tail=4 -> add_new_lvl=0.
4. pressed_en=0, pressed_lvl=B, entries {B,C,A,D}, tail=0 -> add_new_lvl=0. Same case with pressed_en=1 -> add_new_lvl=1 (empty queue).
5. pressed_en=1, pressed_lvl=B, entries {A,C,D,A}, tail=4 and tail=6 -> add_new_lvl=0 (full). With tail=3 and entries {A,C,D,B} -> add_new_lvl=1. Invalid entries driven to X must not produce X on the output.
6. Hold reset=1 over several edges with add_new_lvl=1 -> add_new_lvl_q=0. Release reset -> add_new_lvl_q=1 on the first following edge.
